rm_mul_pipe: RTL
================

Name: rm_mul_pipe

Overview:
- Parametrised, pipelined W x W multiplier built on the four-quadrant recursive split (hh, hl, lh, ll partial products).
- Generalises the fixed 8x8 signed combinational multipliers in three ways: any even width, per-operand signedness (signed x signed, signed x unsigned, unsigned x unsigned), and a 3-stage registered pipeline with valid/ready flow control.
- Sits between operand producers (MAC/filter datapaths) and accumulators that can stall.

Parameters:
- W, 8, operand width; must be even and >= 4. H = W/2 is the quadrant width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- a_signed  input  1  1 = a is two's complement; 0 = a is unsigned.
- b_signed  input  1  1 = b is two's complement; 0 = b is unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2W  exact product, two's complement whenever either operand is signed.

Behaviour:
- Reset is asynchronous, active-high, on clk and rst. While rst is high:
  - all stage valid bits = 0;
  - all data registers = 0;
  - out_valid = 0, product = 0;
  - in_ready = 1 as soon as rst deasserts.
- Arithmetic uses extended high halves of H+1 bits:
  - aH = {a_signed & a[W-1], a[W-1:H]}, signed;
  - aL = a[H-1:0], unsigned;
  - bH and bL are formed the same way from b.
  - The result is exact, with no overflow or truncation loss. Worst cases are -2^(W-1) x -2^(W-1) and (2^W-1)^2; both fit in 2W bits with the stated interpretation.
- Stage 1 (S1) registers four quadrant products plus a valid bit:
  - hh = aH*bH, 2H+2 bits, signed;
  - hl = aH*bL, 2H+1 bits, signed;
  - lh = aL*bH, 2H+1 bits, signed;
  - ll = aL*bL, 2H bits, unsigned.
- Stage 2 (S2) registers:
  - mid = sext(hl) + sext(lh), 2H+2 bits;
  - hh and ll pass through unchanged.
- Stage 3 (S3) registers:
  - product = (sext(hh) << W) + (sext(mid) << H) + zext(ll), modulo 2^(2W);
  - sets out_valid.
- Latency is 3 cycles from an accepted beat (in_valid & in_ready) to out_valid with no stalls. Throughput is 1 beat per cycle.
- Flow control is bubble-collapsing per stage, with vk = stage k valid:
  - S3 advances when out_ready | ~v3;
  - S2 advances when ~v3 | S3 advances;
  - S1 advances when ~v2 | S2 advances;
  - in_ready = ~v1 | S1 advances. This path is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall rules:
  - While out_valid & ~out_ready, product and out_valid hold stable.
  - Upstream stages keep filling until all three are valid, then in_ready = 0.
- Stage registers load only when the stage advances. A stage that advances with no valid input clears its valid bit; its data is don't-care but must not X-propagate.
- Simultaneous accept-and-output in one cycle (full pipe, out_ready = 1, in_valid = 1): one beat leaves, one enters, and occupancy is unchanged.
- The signedness flags travel with their beat, so per-beat mode changes are legal with no bubbles.
- rst asserted mid-operation discards all in-flight beats; no partial output appears after reset.

Decomposition:
- Package rm_mul_pkg:
  - function rm_prod_w(W) = 2*W;
  - localparam-style helper for H;
  - a typedef for the S1 payload struct (hh, hl, lh, ll, valid).
- One sub-module, rm_quad_pp:
  - purely combinational;
  - inputs a, b, a_signed, b_signed;
  - outputs the four quadrant products;
  - parametrised by H.
- Stages 2 and 3 plus all flow control live in rm_mul_pipe.

Test Plan:
- W=8, signed x signed: a=0x80, b=0x80 -> product=0x4000 three cycles after accept. Then a=0x80, b=0x7F -> 0xC080.
- W=8, unsigned x unsigned: a=0xFF, b=0xFF -> 0xFE01. Signed a=0xFF (-1) x unsigned b=0xFF (255) -> 0xFF01. Unsigned a=0xFF x signed b=0xFF -> 0xFF01.
- Back-to-back stream: 20 beats with in_valid=1 and random operands/modes, out_ready=1 -> one product per cycle, in order, all matching the reference model, and in_ready never drops.
- Backpressure: hold out_ready=0 for 6 cycles while streaming -> in_ready falls after 3 beats are held, product stays stable. Release -> beats drain in order with none lost or duplicated.
- Reset mid-flight: 2 beats in the pipe, pulse rst asynchronously between edges -> out_valid=0 and product=0 immediately; no stale beat is emitted after release.
- W=16 random regression, 10k beats across all four mode combinations -> exact match. Corner case: 0x8000 x 0x8000 signed -> 0x40000000.

Source files
------------

// File: rtl/rm_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rm_mul_pkg
// Purpose  : Shared widths, helpers and the stage-1 payload layout for the
//            rm_mul_pipe quadrant-split multiplier.
// Revision : 1.0  initial release
// ============================================================================
package rm_mul_pkg;

    // Width of the full product for a W-bit operand pair.
    function automatic int rm_prod_w(input int w);
        return 2 * w;
    endfunction

    // Width of one quadrant (low half of an operand).
    function automatic int rm_half_w(input int w);
        return w / 2;
    endfunction

    localparam int c_RM_W_DEF = 8;
    localparam int c_RM_H_DEF = c_RM_W_DEF / 2;

    // Stage-1 payload at the default width. The pipeline declares the same
    // layout locally, sized from its own W, because a package type cannot
    // follow a module parameter.
    typedef struct packed {
        logic signed [2*c_RM_H_DEF+1:0] hh;
        logic signed [2*c_RM_H_DEF:0]   hl;
        logic signed [2*c_RM_H_DEF:0]   lh;
        logic        [2*c_RM_H_DEF-1:0] ll;
        logic                           valid;
    } rm_s1_t;

endpackage
`default_nettype wire

// File: rtl/rm_quad_pp.sv
`default_nettype none
// ============================================================================
// Module   : rm_quad_pp
// Purpose  : Combinational four-quadrant partial products. High halves are
//            extended to H+1 bits (signed), low halves stay H-bit unsigned.
// Revision : 1.0  initial release
// ============================================================================
module rm_quad_pp #(
    parameter int H = 4
) (
    input  logic [2*H-1:0]        a,
    input  logic [2*H-1:0]        b,
    input  logic                  a_signed,
    input  logic                  b_signed,
    output logic signed [2*H+1:0] hh,
    output logic signed [2*H:0]   hl,
    output logic signed [2*H:0]   lh,
    output logic [2*H-1:0]        ll
);

    logic signed [H:0]     w_ah;
    logic signed [H:0]     w_bh;
    logic [H-1:0]          w_al;
    logic [H-1:0]          w_bl;
    logic signed [2*H+1:0] w_ah_hh;
    logic signed [2*H+1:0] w_bh_hh;
    logic signed [2*H:0]   w_ah_hl;
    logic signed [2*H:0]   w_bl_hl;
    logic signed [2*H:0]   w_al_lh;
    logic signed [2*H:0]   w_bh_lh;
    logic [2*H-1:0]        w_al_ll;
    logic [2*H-1:0]        w_bl_ll;

    // Split operands; the extra high bit carries the sign only for signed operands.
    always_comb begin
        w_ah = {a_signed & a[2*H-1], a[2*H-1:H]};
        w_bh = {b_signed & b[2*H-1], b[2*H-1:H]};
        w_al = a[H-1:0];
        w_bl = b[H-1:0];
    end

    // Extend every factor to its product width so each multiply is exact in place.
    always_comb begin
        w_ah_hh = {{(H+1){w_ah[H]}}, w_ah};
        w_bh_hh = {{(H+1){w_bh[H]}}, w_bh};
        w_ah_hl = {{H{w_ah[H]}}, w_ah};
        w_bl_hl = {{(H+1){1'b0}}, w_bl};
        w_al_lh = {{(H+1){1'b0}}, w_al};
        w_bh_lh = {{H{w_bh[H]}}, w_bh};
        w_al_ll = {{H{1'b0}}, w_al};
        w_bl_ll = {{H{1'b0}}, w_bl};
    end

    // Quadrant products; each true result fits its destination width.
    always_comb begin
        hh = w_ah_hh * w_bh_hh;
        hl = w_ah_hl * w_bl_hl;
        lh = w_al_lh * w_bh_lh;
        ll = w_al_ll * w_bl_ll;
    end

endmodule
`default_nettype wire

// File: rtl/rm_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rm_mul_pipe
// Purpose  : 3-stage pipelined WxW multiplier with per-operand signedness and
//            bubble-collapsing valid/ready flow control. W must be even, >= 4.
// Revision : 1.0  initial release
// ============================================================================
module rm_mul_pipe
    import rm_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    input  logic                    a_signed,
    input  logic                    b_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [rm_prod_w(W)-1:0] product
);

    localparam int c_H  = rm_half_w(W);
    localparam int c_PW = rm_prod_w(W);

    typedef struct packed {
        logic signed [2*c_H+1:0] hh;
        logic signed [2*c_H:0]   hl;
        logic signed [2*c_H:0]   lh;
        logic        [2*c_H-1:0] ll;
        logic                    valid;
    } s1_t;

    s1_t                     r_s1;
    logic                    r_v2;
    logic signed [2*c_H+1:0] r_s2_hh;
    logic signed [2*c_H+1:0] r_s2_mid;
    logic        [2*c_H-1:0] r_s2_ll;
    logic                    r_v3;
    logic        [c_PW-1:0]  r_product;

    logic signed [2*c_H+1:0] w_hh;
    logic signed [2*c_H:0]   w_hl;
    logic signed [2*c_H:0]   w_lh;
    logic        [2*c_H-1:0] w_ll;
    logic signed [2*c_H+1:0] w_mid;
    logic        [c_PW-1:0]  w_hh_x;
    logic        [c_PW-1:0]  w_mid_x;
    logic        [c_PW-1:0]  w_ll_x;
    logic        [c_PW-1:0]  w_prod;
    logic                    w_s3_adv;
    logic                    w_s2_adv;
    logic                    w_s1_adv;

    rm_quad_pp #(
        .H (c_H)
    ) u_quad_pp (
        .a        (a),
        .b        (b),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .hh       (w_hh),
        .hl       (w_hl),
        .lh       (w_lh),
        .ll       (w_ll)
    );

    // "Stage k advances" means its content moves on; each condition only looks
    // downstream, so in_ready never depends on in_valid.
    always_comb begin
        w_s3_adv = out_ready | ~r_v3;
        w_s2_adv = ~r_v3 | w_s3_adv;
        w_s1_adv = ~r_v2 | w_s2_adv;
        in_ready = ~r_s1.valid | w_s1_adv;
    end

    // Cross terms summed with one guard bit; recombine all quadrants at full width.
    always_comb begin
        w_mid   = {r_s1.hl[2*c_H], r_s1.hl} + {r_s1.lh[2*c_H], r_s1.lh};
        w_hh_x  = {{(c_PW-2*c_H-2){r_s2_hh[2*c_H+1]}}, r_s2_hh};
        w_mid_x = {{(c_PW-2*c_H-2){r_s2_mid[2*c_H+1]}}, r_s2_mid};
        w_ll_x  = {{(c_PW-2*c_H){1'b0}}, r_s2_ll};
        w_prod  = (w_hh_x << W) + (w_mid_x << c_H) + w_ll_x;
    end

    // Stage 1: capture quadrant products of an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (in_ready) begin
            r_s1.valid <= in_valid;
            if (in_valid) begin
                r_s1.hh <= w_hh;
                r_s1.hl <= w_hl;
                r_s1.lh <= w_lh;
                r_s1.ll <= w_ll;
            end
        end
    end

    // Stage 2: merge the cross terms, pass hh and ll through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_s2_hh  <= '0;
            r_s2_mid <= '0;
            r_s2_ll  <= '0;
        end else if (w_s1_adv) begin
            r_v2 <= r_s1.valid;
            if (r_s1.valid) begin
                r_s2_hh  <= r_s1.hh;
                r_s2_mid <= w_mid;
                r_s2_ll  <= r_s1.ll;
            end
        end
    end

    // Stage 3: register the final product; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3      <= 1'b0;
            r_product <= '0;
        end else if (w_s2_adv) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_product <= w_prod;
            end
        end
    end

    assign out_valid = r_v3;
    assign product   = r_product;

endmodule
`default_nettype wire
